// File: rtl/audio_mixer_pkg.sv
// -----------------------------------------------------------------------------
// audio_mixer_pkg
// Shared constants for the N-channel audio mixer: beeper weights, CTRL
// register bit positions, the mix sequencer state encoding and a helper
// that forms the weighted beeper sum.
// -----------------------------------------------------------------------------
package audio_mixer_pkg;

  localparam logic [7:0] BEEP_SPK = 8'h60;
  localparam logic [7:0] BEEP_EAR = 8'h20;
  localparam logic [7:0] BEEP_MIC = 8'h10;

  localparam int CTRL_MUTE_BIT    = 0;
  localparam int CTRL_BEEP_EN_BIT = 1;
  localparam int CTRL_OVERRUN_BIT = 6;
  localparam int CTRL_CLIP_BIT    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_BEEP = 2'd2,
    ST_SAT  = 2'd3
  } mix_state_e;

  // Largest result is 8'h90, so the 8-bit sum never wraps.
  function automatic logic [7:0] beep_weight(input logic spk, input logic ear,
                                             input logic mic);
    logic [7:0] s;
    s = 8'h00;
    if (spk) s = s + BEEP_SPK;
    if (ear) s = s + BEEP_EAR;
    if (mic) s = s + BEEP_MIC;
    return s;
  endfunction

endpackage

// File: rtl/sd_modulator.sv
// -----------------------------------------------------------------------------
// sd_modulator
// Turns the held mix sample into a 1-bit pin stream.
// Build option: AUDIO_MIXER_SD2_EN selects a second-order modulator;
// otherwise a first-order (carry-out accumulator) modulator is built.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high; clears integrators and output bit
//   sample_i  unsigned SW-bit sample, evaluated every clock
//   bit_o     registered modulator output
// -----------------------------------------------------------------------------
module sd_modulator #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [SW-1:0] sample_i,
  output logic          bit_o
);

`ifdef AUDIO_MIXER_SD2_EN
  localparam int IW = SW + 3;
  localparam int EW = IW + 2;
  localparam logic signed [IW-1:0] FS = IW'(2 ** SW);
  localparam logic signed [EW-1:0] HI = EW'((2 ** (IW - 1)) - 1);
  localparam logic signed [EW-1:0] LO = EW'(-(2 ** (IW - 1)));

  logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;
  logic signed [IW-1:0] x_s, fb;
  logic signed [EW-1:0] sum1, sum2;
  logic                 bit_q, bit_d;

  // Integrators clamp instead of wrapping so a full-scale input cannot
  // flip the sign of the loop state.
  function automatic logic signed [IW-1:0] clamp(input logic signed [EW-1:0] v);
    if (v > HI) return HI[IW-1:0];
    if (v < LO) return LO[IW-1:0];
    return v[IW-1:0];
  endfunction

  always_comb begin
    // Sample is re-centred to -2^SW..+2^SW-2 so it spans the feedback range.
    x_s   = IW'({2'b00, sample_i, 1'b0}) - FS;
    fb    = bit_q ? FS : -FS;
    sum1  = EW'(i1_q) + EW'(x_s) - EW'(fb);
    sum2  = EW'(i2_q) + EW'(i1_q) - EW'(fb);
    i1_d  = clamp(sum1);
    i2_d  = clamp(sum2);
    bit_d = ~i2_d[IW-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i1_q  <= '0;
      i2_q  <= '0;
      bit_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;
`else
  logic [SW-1:0] sd_q, sd_d;
  logic [SW:0]   sum;
  logic          bit_q, bit_d;

  always_comb begin
    sum   = {1'b0, sd_q} + {1'b0, sample_i};
    sd_d  = sum[SW-1:0];
    bit_d = sum[SW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_q  <= '0;
      bit_q <= 1'b0;
    end else begin
      sd_q  <= sd_d;
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;
`endif

endmodule

// File: rtl/audio_mixer_n.sv
// -----------------------------------------------------------------------------
// audio_mixer_n
// N-channel PCM mixer with 4-bit per-channel volume, weighted beeper bits,
// saturation, mute and a sigma-delta pin output. Volume and CTRL live in
// ZX-Uno register space starting at REGBASE.
// Build option: AUDIO_MIXER_SD2_EN (inside sd_modulator) selects the
// second-order modulator; the register file and mix path are unaffected.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   addr, ior, iow    ZX-Uno register number, data-port read / write strobe
//   din, dout, oe_n   CPU write data, read data, read-select (low = drive bus)
//   ch_data           NCH packed unsigned SW-bit channels, ch i at [i*SW +: SW]
//   sample_tick       one-cycle strobe starting a mix
//   spk, mic, ear     beeper sources
//   mix_out           last saturated mix
//   mix_strobe        one-cycle pulse when mix_out updates
//   audio_out         modulator bit
//
// State    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a tick (live or pending)
// ST_ACC   | one channel multiply-accumulate per clock, idx 0..NCH-1
// ST_BEEP  | add weighted beeper bits when beep_en
// ST_SAT   | scale down, saturate, mute, load mix_out; restart if pending
// -----------------------------------------------------------------------------
module audio_mixer_n
  import audio_mixer_pkg::*;
#(
  parameter int         NCH     = 4,
  parameter int         SW      = 8,
  parameter int         VW      = 4,
  parameter logic [7:0] REGBASE = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        addr,
  input  logic              ior,
  input  logic              iow,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              oe_n,
  input  logic [NCH*SW-1:0] ch_data,
  input  logic              sample_tick,
  input  logic              spk,
  input  logic              mic,
  input  logic              ear,
  output logic [SW-1:0]     mix_out,
  output logic              mix_strobe,
  output logic              audio_out
);

  localparam int ACCW = SW + VW + $clog2(NCH + 2);
  localparam int MW   = ACCW - VW;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = SW + VW;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [VW-1:0] vol_q [NCH];
  logic [VW-1:0] vol_d [NCH];
  logic          mute_q, mute_d;
  logic          beep_en_q, beep_en_d;
  logic          overrun_q, overrun_d;
  logic          clip_q, clip_d;
  logic          overrun_set, clip_set;

  logic [7:0] reg_off;
  logic       in_range;
  logic       ctrl_sel;
  logic [7:0] ctrl_rd;
  logic       unused_din;

  // Offset arithmetic wraps, so addresses below REGBASE land out of range.
  assign reg_off  = addr - REGBASE;
  assign in_range = (reg_off <= 8'(NCH));
  assign ctrl_sel = (reg_off == 8'(NCH));
  assign unused_din = ^din;

  always_comb begin
    ctrl_rd                   = 8'h00;
    ctrl_rd[CTRL_MUTE_BIT]    = mute_q;
    ctrl_rd[CTRL_BEEP_EN_BIT] = beep_en_q;
    ctrl_rd[CTRL_OVERRUN_BIT] = overrun_q;
    ctrl_rd[CTRL_CLIP_BIT]    = clip_q;
  end

  always_comb begin
    oe_n = !(ior && in_range);
    dout = 8'h00;
    if (ctrl_sel) begin
      dout = ctrl_rd;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (reg_off == 8'(i)) dout = 8'(vol_q[i]);
      end
    end
  end

  always_comb begin
    vol_d     = vol_q;
    mute_d    = mute_q;
    beep_en_d = beep_en_q;
    overrun_d = overrun_q;
    clip_d    = clip_q;
    if (iow) begin
      for (int i = 0; i < NCH; i++) begin
        if (reg_off == 8'(i)) vol_d[i] = din[VW-1:0];
      end
      if (ctrl_sel) begin
        mute_d    = din[CTRL_MUTE_BIT];
        beep_en_d = din[CTRL_BEEP_EN_BIT];
        if (din[CTRL_OVERRUN_BIT]) overrun_d = 1'b0;
        if (din[CTRL_CLIP_BIT])    clip_d    = 1'b0;
      end
    end
    // A hardware event in the same cycle as a clear must not be lost.
    if (overrun_set) overrun_d = 1'b1;
    if (clip_set)    clip_d    = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Mix sequencer and MAC
  // ---------------------------------------------------------------------------
  mix_state_e     state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            pending_q, pending_d;
  logic [SW-1:0]   snap_ch_q  [NCH];
  logic [SW-1:0]   snap_ch_d  [NCH];
  logic [VW-1:0]   snap_vol_q [NCH];
  logic [VW-1:0]   snap_vol_d [NCH];
  logic [SW-1:0]   mix_q, mix_d;
  logic            strobe_q, strobe_d;

  logic            start;
  logic [PW-1:0]   prod;
  logic [MW-1:0]   m;
  logic [SW-1:0]   m_sat;

  assign prod = PW'(snap_ch_q[idx_q]) * PW'(snap_vol_q[idx_q]);
  assign m    = acc_q[ACCW-1:VW];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    pending_d   = pending_q;
    snap_ch_d   = snap_ch_q;
    snap_vol_d  = snap_vol_q;
    mix_d       = mix_q;
    strobe_d    = 1'b0;
    overrun_set = 1'b0;
    clip_set    = 1'b0;
    start       = 1'b0;
    m_sat       = m[SW-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick || pending_q) start = 1'b1;
      end
      ST_ACC: begin
        acc_d = acc_q + ACCW'(prod);
        if (idx_q == IDXW'(NCH - 1)) begin
          idx_d   = '0;
          state_d = ST_BEEP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_BEEP: begin
        if (beep_en_q) acc_d = acc_q + (ACCW'(beep_weight(spk, ear, mic)) << VW);
        state_d = ST_SAT;
      end
      ST_SAT: begin
        if (m > MW'({SW{1'b1}})) begin
          m_sat    = '1;
          clip_set = 1'b1;
        end
        mix_d    = mute_q ? '0 : m_sat;
        strobe_d = 1'b1;
        state_d  = ST_IDLE;
        // A queued tick starts straight away, skipping the idle cycle.
        if (pending_q) start = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      for (int i = 0; i < NCH; i++) snap_ch_d[i] = ch_data[i*SW +: SW];
      snap_vol_d = vol_q;
      acc_d      = '0;
      idx_d      = '0;
      state_d    = ST_ACC;
      pending_d  = 1'b0;
    end

    // Ticks that arrive mid-mix collapse into a single queued tick.
    if (sample_tick && (state_q != ST_IDLE)) begin
      pending_d   = 1'b1;
      overrun_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      pending_q <= 1'b0;
      mix_q     <= '0;
      strobe_q  <= 1'b0;
      mute_q    <= 1'b0;
      beep_en_q <= 1'b1;
      overrun_q <= 1'b0;
      clip_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        vol_q[i]      <= '1;
        snap_ch_q[i]  <= '0;
        snap_vol_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      pending_q  <= pending_d;
      mix_q      <= mix_d;
      strobe_q   <= strobe_d;
      mute_q     <= mute_d;
      beep_en_q  <= beep_en_d;
      overrun_q  <= overrun_d;
      clip_q     <= clip_d;
      vol_q      <= vol_d;
      snap_ch_q  <= snap_ch_d;
      snap_vol_q <= snap_vol_d;
    end
  end

  assign mix_out    = mix_q;
  assign mix_strobe = strobe_q;

  sd_modulator #(
    .SW(SW)
  ) u_sd (
    .clk     (clk),
    .reset   (reset),
    .sample_i(mix_q),
    .bit_o   (audio_out)
  );

endmodule

// File: tb/tb_audio_mixer_n.sv
module tb_audio_mixer_n;
  localparam int NCH = 4;
  localparam int SW  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        addr = 8'h00;
  logic              ior = 1'b0;
  logic              iow = 1'b0;
  logic [7:0]        din = 8'h00;
  logic [7:0]        dout;
  logic              oe_n;
  logic [NCH*SW-1:0] ch_data = '0;
  logic              sample_tick = 1'b0;
  logic              spk = 1'b0;
  logic              mic = 1'b0;
  logic              ear = 1'b0;
  logic [SW-1:0]     mix_out;
  logic              mix_strobe;
  logic              audio_out;

  int n_chk  = 0;
  int n_pass = 0;

  audio_mixer_n #(.NCH(NCH), .SW(SW), .VW(4), .REGBASE(8'hF0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .ior(ior), .iow(iow), .din(din),
    .dout(dout), .oe_n(oe_n), .ch_data(ch_data), .sample_tick(sample_tick),
    .spk(spk), .mic(mic), .ear(ear), .mix_out(mix_out),
    .mix_strobe(mix_strobe), .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; iow = 1'b1;
    step();
    iow = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
    addr = a; ior = 1'b1;
    #1;
    d = dout; oe = oe_n;
    ior = 1'b0;
    #1;
  endtask

  // Steps until mix_strobe is seen; n counts edges since the tick edge.
  task automatic wait_strobe(input int start, output int n);
    bit got;
    got = 1'b0;
    n = start;
    while (!got && n < start + 20) begin
      step();
      n++;
      if (mix_strobe) got = 1'b1;
    end
    if (!got) n = 999;
  endtask

  task automatic run_mix(output int lat);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    wait_strobe(0, lat);
  endtask

  logic [7:0] rdata;
  logic       roe;
  int         lat, lat2, ones, bad, last, extra;

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_mix_out", mix_out, 8'h00);
    chk("rst_audio_out", audio_out, 1'b0);
    chk("rst_strobe", mix_strobe, 1'b0);
    rd(8'hF0, rdata, roe);
    chk("rst_vol0", rdata, 8'h0F);
    chk("rst_vol0_oe_n", roe, 1'b0);
    rd(8'hF4, rdata, roe);
    chk("rst_ctrl", rdata, 8'h02);
    rd(8'hF5, rdata, roe);
    chk("out_of_range_oe_n", roe, 1'b1);
    chk("out_of_range_dout", rdata, 8'h00);

    // Single channel at full volume, no beeper
    wr(8'hF1, 8'h00); wr(8'hF2, 8'h00); wr(8'hF3, 8'h00);
    wr(8'hF4, 8'h00);
    ch_data = {8'h00, 8'h00, 8'h00, 8'h80};
    run_mix(lat);
    chk("ch0_latency", lat, 6);
    chk("ch0_mix", mix_out, 8'h78);
    step();
    chk("strobe_one_cycle", mix_strobe, 1'b0);
    rd(8'hF4, rdata, roe);
    chk("ch0_ctrl_noclip", rdata, 8'h00);

    // Saturation and clip clear
    for (int i = 0; i < NCH; i++) wr(8'hF0 + 8'(i), 8'h0F);
    ch_data = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_mix(lat);
    chk("clip_latency", lat, 6);
    chk("clip_mix", mix_out, 8'hFF);
    rd(8'hF4, rdata, roe);
    chk("clip_flag_set", rdata, 8'h80);
    wr(8'hF4, 8'h80);
    rd(8'hF4, rdata, roe);
    chk("clip_flag_cleared", rdata, 8'h00);

    // Beeper path and mute
    for (int i = 0; i < NCH; i++) wr(8'hF0 + 8'(i), 8'h00);
    wr(8'hF4, 8'h02);
    spk = 1'b1;
    run_mix(lat);
    chk("beep_spk_mix", mix_out, 8'h60);
    spk = 1'b0; ear = 1'b1; mic = 1'b1;
    run_mix(lat);
    chk("beep_ear_mic_mix", mix_out, 8'h30);
    ear = 1'b0; mic = 1'b0; spk = 1'b1;
    wr(8'hF4, 8'h03);
    rd(8'hF4, rdata, roe);
    chk("mute_ctrl_read", rdata, 8'h03);
    run_mix(lat);
    chk("mute_mix", mix_out, 8'h00);
    wr(8'hF4, 8'h00);
    run_mix(lat);
    chk("beep_disabled_mix", mix_out, 8'h00);
    spk = 1'b0;

    // First-order modulator density at mix_out = 0x40
    wr(8'hF0, 8'h08);
    ch_data = {8'h00, 8'h00, 8'h00, 8'h80};
    run_mix(lat);
    chk("sd_mix", mix_out, 8'h40);
    step();
    ones = 0; bad = 0; last = -1;
    for (int k = 0; k < 256; k++) begin
      step();
      if (audio_out) begin
        ones++;
        if (last >= 0 && (k - last) != 4) bad++;
        last = k;
      end
    end
    chk("sd_ones_per_256", ones, 64);
    chk("sd_bad_gaps", bad, 0);

    // Overrun: ticks at edges 0, 2 and 3; second mix snapshots at edge 6
    wr(8'hF0, 8'h0F);
    ch_data = {8'h00, 8'h00, 8'h00, 8'h10};
    sample_tick = 1'b1; step();   // edge 0
    sample_tick = 1'b0; step();   // edge 1
    sample_tick = 1'b1; step();   // edge 2
    step();                       // edge 3
    sample_tick = 1'b0;
    ch_data = {8'h00, 8'h00, 8'h00, 8'h20};
    wait_strobe(3, lat);
    chk("ovr_first_latency", lat, 6);
    chk("ovr_first_mix", mix_out, 8'h0F);
    ch_data = {8'h00, 8'h00, 8'h00, 8'h30};
    wait_strobe(0, lat2);
    chk("ovr_second_spacing", lat2, 6);
    chk("ovr_second_mix", mix_out, 8'h1E);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (mix_strobe) extra++;
    end
    chk("ovr_collapsed_ticks", extra, 0);
    rd(8'hF4, rdata, roe);
    chk("ovr_flag_set", rdata, 8'h40);
    wr(8'hF4, 8'h40);
    rd(8'hF4, rdata, roe);
    chk("ovr_flag_cleared", rdata, 8'h00);

    // Reset in the middle of ACC
    ch_data = {8'h00, 8'h00, 8'h00, 8'h80};
    sample_tick = 1'b1; step();
    sample_tick = 1'b0;
    step(); step();
    reset = 1'b1;
    extra = 0;
    step();
    if (mix_strobe) extra++;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (mix_strobe) extra++;
    end
    chk("rst_mid_no_strobe", extra, 0);
    chk("rst_mid_mix_out", mix_out, 8'h00);
    rd(8'hF4, rdata, roe);
    chk("rst_mid_ctrl", rdata, 8'h02);
    rd(8'hF0, rdata, roe);
    chk("rst_mid_vol0", rdata, 8'h0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
